// File: rtl/adder_pkg.sv
// adder_pkg -- shared definitions for the sequential adder.
// Holds the FSM state encoding and the default operand/slice widths so the
// top level and any testbench agree on them.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder -- combinational CHUNK-bit ripple-carry adder built from
// full-adder cells.
// Ports:
//   a, b      in   CHUNK  slice operands
//   c_in      in   1      carry into bit 0 of the slice
//   sum       out  CHUNK  slice sum
//   c_out     out  1      carry out of the slice MSB
//   c_msb_in  out  1      carry into the slice MSB (used for signed overflow)
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [CHUNK:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out    = carry[CHUNK];
  assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// seq_adder -- multi-cycle adder that processes CHUNK bits per clock,
// least significant slice first, with the carry registered between slices.
// Optional feature macro: SEQ_ADDER_SUB_EN adds the 'sub' port and the
// a + ~b + 1 subtract mode.
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      accept operands (honoured in IDLE or DONE only)
//   a, b   in   WIDTH  operands
//   c_in   in   1      carry into bit 0
//   sub    in   1      subtract mode (only with SEQ_ADDER_SUB_EN)
//   busy   out  1      operation in progress
//   done   out  1      one-cycle result-valid pulse
//   sum    out  WIDTH  result, held until the next operation completes
//   c_out  out  1      carry out of the MSB (1 = no borrow when subtracting)
//   ovf    out  1      two's-complement overflow
module seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("seq_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_t             state;
  state_t             next_state;
  logic               accept;
  logic               last;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic [CHUNK-1:0]   slice_sum;
  logic               slice_cout;
  logic               slice_cmsb;
  logic [WIDTH-1:0]   b_eff;
  logic               c_eff;

  // Subtraction is folded into the operands at capture time, so the
  // slice datapath only ever adds.
`ifdef SEQ_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : c_in;
`else
  assign b_eff = b;
  assign c_eff = c_in;
`endif

  assign last = (cnt == CNT_W'(N - 1));

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a        (a_r[CHUNK-1:0]),
    .b        (b_r[CHUNK-1:0]),
    .c_in     (carry),
    .sum      (slice_sum),
    .c_out    (slice_cout),
    .c_msb_in (slice_cmsb)
  );

  // Partial result fills from the top: after N shifts the first slice
  // has reached bit 0 and the register holds the full sum.
  always_comb begin
    acc_next = acc >> CHUNK;
    acc_next[WIDTH-1 -: CHUNK] = slice_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Start is only honoured outside RUN; accepting in DONE gives
  // back-to-back operation without an idle cycle.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands shift down one slice per cycle; visible results change only
  // on the final slice so they stay stable for a full operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      acc   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      a_r   <= a;
      b_r   <= b_eff;
      carry <= c_eff;
    end else if (state == RUN) begin
      cnt   <= cnt + CNT_W'(1);
      a_r   <= a_r >> CHUNK;
      b_r   <= b_r >> CHUNK;
      carry <= slice_cout;
      acc   <= acc_next;
      if (last) begin
        sum   <= acc_next;
        c_out <= slice_cout;
        ovf   <= slice_cout ^ slice_cmsb;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder -- self-checking bench for seq_adder (WIDTH=16, CHUNK=4) plus
// a CHUNK=16 instance for the single-cycle configuration. Expected results
// come from whole-word arithmetic on the operands.
// Honours SEQ_ADDER_SUB_EN when defined.
module tb_seq_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              start16;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              c_in;
`ifdef SEQ_ADDER_SUB_EN
  logic              sub;
`endif
  logic              busy, done, c_out, ovf;
  logic [WIDTH-1:0]  sum;
  logic              busy16, done16, c_out16, ovf16;
  logic [WIDTH-1:0]  sum16;

  int checks = 0;
  int passed = 0;

  logic [WIDTH-1:0]  exp_sum;
  logic              exp_cout;
  logic              exp_ovf;
  logic [WIDTH-1:0]  prev_sum;

  always #5 clk = ~clk;

  seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SEQ_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  seq_adder #(.WIDTH(WIDTH), .CHUNK(WIDTH)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SEQ_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .c_out (c_out16),
    .ovf   (ovf16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Whole-word reference: 17-bit sum, overflow from operand/result signs.
  task automatic model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] be;
    logic             ce;
    be = bv;
    ce = cv;
`ifdef SEQ_ADDER_SUB_EN
    if (sub) begin
      be = ~bv;
      ce = 1'b1;
    end
`endif
    full     = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, ce};
    exp_sum  = full[WIDTH-1:0];
    exp_cout = full[WIDTH];
    exp_ovf  = (av[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]);
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    @(negedge clk);
    a        = av;
    b        = bv;
    c_in     = cv;
    start    = 1'b1;
    prev_sum = exp_sum;
    model(av, bv, cv);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done (bounded), then compares latency, busy length and results.
  task automatic check_output(input string tag, input int exp_lat);
    int cyc;
    int busy_cyc;
    bit held;
    cyc      = 0;
    busy_cyc = 0;
    held     = 1'b1;
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      if (sum !== prev_sum) held = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, ".done"},    32'(done),     32'd1);
    check({tag, ".latency"}, 32'(cyc),      32'(exp_lat));
    check({tag, ".busy"},    32'(busy_cyc), 32'(exp_lat));
    check({tag, ".held"},    32'(held),     32'd1);
    check({tag, ".sum"},     32'(sum),      32'(exp_sum));
    check({tag, ".c_out"},   32'(c_out),    32'(exp_cout));
    check({tag, ".ovf"},     32'(ovf),      32'(exp_ovf));
  endtask

  task automatic check_pulse_end(input string tag);
    @(posedge clk);
    #1;
    check({tag, ".done_drop"}, 32'(done), 32'd0);
    check({tag, ".idle"},      32'(busy), 32'd0);
    check({tag, ".stable"},    32'(sum),  32'(exp_sum));
  endtask

  initial begin
    int dones;
    rst_n   = 1'b1;
    start   = 1'b0;
    start16 = 1'b0;
    a       = '0;
    b       = '0;
    c_in    = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    sub     = 1'b0;
`endif
    exp_sum  = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy",  32'(busy),  32'd0);
    check("reset.done",  32'(done),  32'd0);
    check("reset.sum",   32'(sum),   32'd0);
    check("reset.c_out", 32'(c_out), 32'd0);
    check("reset.ovf",   32'(ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-ones plus one wraps to zero with carry out
    apply_stimulus(16'hFFFF, 16'h0001, 1'b0);
    check("wrap.busy_start", 32'(busy), 32'd1);
    check_output("wrap", N);
    check("wrap.const_sum", 32'(sum), 32'h0000);
    check_pulse_end("wrap");

    // Signed overflow, then a back-to-back start accepted while in DONE
    apply_stimulus(16'h7FFF, 16'h0001, 1'b0);
    check_output("ovf", N);
    check("ovf.const_sum", 32'(sum), 32'h8000);
    check("ovf.const_ovf", 32'(ovf), 32'd1);
    apply_stimulus(16'h1234, 16'h1111, 1'b1);
    check("b2b.no_bubble", 32'(busy), 32'd1);
    check("b2b.done_low",  32'(done), 32'd0);
    check_output("b2b", N);
    check("b2b.const_sum", 32'(sum), 32'h2346);
    check_pulse_end("b2b");

    // A second start while running must be ignored
    apply_stimulus(16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    a     = 16'h00FF;
    b     = 16'h00FF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("ignore", N - 1);
    check("ignore.const_sum", 32'(sum), 32'h0002);
    check_pulse_end("ignore");
    dones = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("ignore.no_second_done", 32'(dones), 32'd0);

    // Reset in the second RUN cycle aborts the operation
    apply_stimulus(16'h0100, 16'h0200, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.busy",  32'(busy),  32'd0);
    check("abort.done",  32'(done),  32'd0);
    check("abort.sum",   32'(sum),   32'd0);
    check("abort.c_out", 32'(c_out), 32'd0);
    check("abort.ovf",   32'(ovf),   32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    exp_sum  = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    dones    = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort.no_done", 32'(dones), 32'd0);
    apply_stimulus(16'h0003, 16'h0004, 1'b0);
    check_output("post_abort", N);
    check("post_abort.const_sum", 32'(sum), 32'h0007);
    check_pulse_end("post_abort");

`ifdef SEQ_ADDER_SUB_EN
    // Subtract mode: c_in is ignored, c_out=1 means no borrow
    sub = 1'b1;
    apply_stimulus(16'h0005, 16'h0007, 1'b1);
    check_output("sub_neg", N);
    check("sub_neg.const_sum",  32'(sum),   32'hFFFE);
    check("sub_neg.const_cout", 32'(c_out), 32'd0);
    check_pulse_end("sub_neg");
    apply_stimulus(16'h0007, 16'h0005, 1'b0);
    check_output("sub_pos", N);
    check("sub_pos.const_sum",  32'(sum),   32'h0002);
    check("sub_pos.const_cout", 32'(c_out), 32'd1);
    check_pulse_end("sub_pos");
    sub = 1'b0;
`endif

    // Randomized operations, sometimes back to back
    for (int i = 0; i < 16; i++) begin
`ifdef SEQ_ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      apply_stimulus(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)));
      check_output($sformatf("rand%0d", i), N);
      if ($urandom_range(0, 1) == 0) begin
        check_pulse_end($sformatf("rand%0d", i));
      end
    end
`ifdef SEQ_ADDER_SUB_EN
    sub = 1'b0;
`endif
    check_pulse_end("rand_tail");

    // Single-slice configuration: result one cycle after start
    @(negedge clk);
    a       = 16'h8000;
    b       = 16'h8000;
    c_in    = 1'b0;
    start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    check("c16.busy",  32'(busy16),  32'd1);
    check("c16.early", 32'(done16),  32'd0);
    @(posedge clk);
    #1;
    check("c16.done",  32'(done16),  32'd1);
    check("c16.sum",   32'(sum16),   32'h0000);
    check("c16.c_out", 32'(c_out16), 32'd1);
    check("c16.ovf",   32'(ovf16),   32'd1);
    @(posedge clk);
    #1;
    check("c16.done_drop", 32'(done16), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and a violating configuration SHALL fail at elaboration.
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to accept the operands this cycle.
REQ-006 a, b  input  WIDTH  operands.
REQ-007 c_in  input  1  carry-in for bit 0.
REQ-008 sub  input  1  subtract mode; this port SHALL exist only when SEQ_ADDER_SUB_EN is defined.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse: the result is valid.
REQ-011 sum  output  WIDTH  result.
REQ-012 c_out  output  1  carry out of the MSB.
REQ-013 ovf  output  1  two's-complement signed overflow.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE, with N = WIDTH/CHUNK.
REQ-015 In IDLE or DONE, start=1 SHALL capture a, b and c_in (and sub, if built), clear the chunk counter, and enter RUN.
REQ-016 In RUN, each cycle SHALL add one CHUNK slice, LSB slice first, with the carry registered between slices; after the Nth slice the FSM SHALL enter DONE.
REQ-017 Latency: with start sampled at edge 0, done SHALL be high in the cycle following edge N; for CHUNK=WIDTH the latency SHALL be 1.
REQ-018 busy SHALL equal (state==RUN); done SHALL equal (state==DONE) and be high for exactly one cycle; DONE SHALL return to IDLE unless start=1.
REQ-019 start during RUN SHALL be ignored, with no effect on the operands or the result.
REQ-020 sum, c_out and ovf SHALL be updated only on the transition into DONE and SHALL be held stable until the next accepted operation completes.
REQ-021 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-022 Back-to-back operation: start in DONE SHALL begin a new operation with no idle bubble.

Reset
REQ-023 rst_n=0 SHALL immediately force state to IDLE and clear busy, done, sum, c_out, ovf, the counter and the captured operands to 0.
REQ-024 A reset during RUN SHALL abort the operation; done SHALL NOT assert for the aborted operation.

Configuration
REQ-025 With SEQ_ADDER_SUB_EN defined, sub=1 SHALL compute a + ~b + 1 (c_in ignored), and c_out=1 SHALL mean no borrow.
REQ-026 Without SEQ_ADDER_SUB_EN, the sub port and its logic SHALL be absent and the block SHALL compute a + b + c_in only.

Structure
REQ-027 The FSM state encoding (IDLE=0, RUN=1, DONE=2) and the default WIDTH and CHUNK SHALL reside in the shared package adder_pkg.
REQ-028 The slice arithmetic SHALL be a sub-module chunk_adder (parameter CHUNK; ports a, b, c_in, sum, c_out, c_msb_in) built as a ripple of full-adder cells.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-029 a=0xFFFF, b=0x0001, c_in=0, start pulse -> busy high for 4 cycles, then done for 1 cycle with sum=0x0000, c_out=1, ovf=0.
REQ-030 a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1; then a=0x1234, b=0x1111, c_in=1 started in DONE -> sum=0x2346 with no idle cycle.
REQ-031 start with a=0x0001, b=0x0001, then start with a=0x00FF, b=0x00FF during RUN -> single done with sum=0x0002; the second request is ignored.
REQ-032 rst_n low for 1 cycle at the 2nd RUN cycle -> all outputs 0 immediately; no done; a following start with a=0x0003, b=0x0004 -> sum=0x0007.
REQ-033 With SEQ_ADDER_SUB_EN, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0; a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.
REQ-034 With CHUNK=16, a=0x8000, b=0x8000 -> done 1 cycle after start with sum=0x0000, c_out=1, ovf=1.
